// File: rtl/kv_cdc_pkg.sv
// kv_cdc_pkg: shared types and constants for the req/ack CDC transmit and receive ends.
//   kv_cdc_state_t  : handshake FSM state (INIT/IDLE/REQ/REL)
//   KV_CDC_MIN_SYNC : smallest legal synchroniser depth
//   cnt_width()     : counter width able to hold 0..n, never narrower than 1 bit
package kv_cdc_pkg;
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_REQ, ST_REL} kv_cdc_state_t;
    localparam int KV_CDC_MIN_SYNC = 2;
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction
endpackage

// File: rtl/kv_cdc_req_tx_if.sv
// kv_cdc_req_tx_if: local valid/ready word input plus the cross-domain req/ack/data lines.
//   in_valid/in_ready/in_data : local word handshake
//   req_o/data_o/ack_i        : four-phase request, held word, destination acknowledge
//   done_o/err_o/err_clr      : completion pulse, sticky timeout flag, flag clear
//   master : drives the local word, the acknowledge and the clear
//   slave  : the transmit block
interface kv_cdc_req_tx_if #(parameter int DW = 32);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          req_o;
    logic [DW-1:0] data_o;
    logic          ack_i;
    logic          done_o;
    logic          err_o;
    logic          err_clr;
    modport master (output in_valid, in_data, ack_i, err_clr,
                    input  in_ready, req_o, data_o, done_o, err_o);
    modport slave  (input  in_valid, in_data, ack_i, err_clr,
                    output in_ready, req_o, data_o, done_o, err_o);
endinterface

// File: rtl/kv_sync_l2l_sr.sv
// kv_sync_l2l_sr: STAGES-deep level synchroniser with synchronous active-low reset.
//   clk, resetn : destination clock and reset
//   d           : asynchronous level in
//   q           : synchronised level out
module kv_sync_l2l_sr
    import kv_cdc_pkg::*;
#(
    parameter int   STAGES  = KV_CDC_MIN_SYNC,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr;
    always_ff @(posedge clk) begin
        if (!resetn) sr <= {STAGES{RST_VAL}};
        else         sr <= {sr[STAGES-2:0], d};
    end
    assign q = sr[STAGES-1];
endmodule

// File: rtl/kv_cdc_req_tx.sv
// kv_cdc_req_tx: source end of a four-phase req/ack CDC handshake carrying one word per transfer.
//   clk    : source clock
//   resetn : synchronous active-low reset
//   bus    : slave side of kv_cdc_req_tx_if (word in, req/data/ack, done/err/err_clr)
module kv_cdc_req_tx
    import kv_cdc_pkg::*;
#(
    parameter int DW         = 32,
    parameter int SYNC_STAGE = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    kv_cdc_req_tx_if.slave    bus
);
    localparam int IW = cnt_width(SYNC_STAGE);
    localparam int PW = cnt_width(TIMEOUT);
    kv_cdc_state_t state;
    logic          ack_s;
    logic [IW-1:0] init_cnt;
    logic [PW-1:0] ph_cnt;
    logic          waiting;
    logic          adv;
    logic          hit;
    kv_sync_l2l_sr #(.STAGES(SYNC_STAGE), .RST_VAL(1'b0)) u_ack_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (bus.ack_i),
        .q      (ack_s)
    );
    assign bus.in_ready = (state == ST_IDLE);
    assign waiting = (state == ST_REQ) || (state == ST_REL);
    // the current phase completes at this edge
    assign adv = (state == ST_REQ) ? ack_s : (state == ST_REL) ? !ack_s : 1'b0;
    // timeout only counts against a phase that is still stuck at this edge
    assign hit = (TIMEOUT != 0) && waiting && !adv && (ph_cnt == PW'(TIMEOUT - 1));
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_INIT;
            bus.req_o   <= 1'b0;
            bus.data_o  <= '0;
            bus.done_o  <= 1'b0;
            bus.err_o   <= 1'b0;
            init_cnt    <= '0;
            ph_cnt      <= '0;
        end else begin
            bus.done_o <= 1'b0;
            bus.err_o  <= hit | (bus.err_o & ~bus.err_clr);
            ph_cnt     <= (!waiting || adv) ? '0 : hit ? ph_cnt : ph_cnt + 1'b1;
            case (state)
                // wait for the synchroniser to flush, then for any stale ack to be released
                ST_INIT: begin
                    if (init_cnt != IW'(SYNC_STAGE)) init_cnt <= init_cnt + 1'b1;
                    else if (!ack_s)                 state    <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        bus.data_o <= bus.in_data;
                        bus.req_o  <= 1'b1;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack_s) begin
                        bus.req_o <= 1'b0;
                        state     <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (!ack_s) begin
                        bus.done_o <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_kv_cdc_req_tx.sv
// tb_kv_cdc_req_tx: directed bench for kv_cdc_req_tx (SYNC_STAGE=2, TIMEOUT=8), acting as both word source and destination.
module tb_kv_cdc_req_tx;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int n_chk = 0;
    int n_pass = 0;
    int n_done = 0;
    kv_cdc_req_tx_if #(.DW(32)) bus ();
    kv_cdc_req_tx #(.DW(32), .SYNC_STAGE(2), .TIMEOUT(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (bus.done_o) n_done++;
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    initial begin
        int c;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.ack_i    = 1'b0;
        bus.err_clr  = 1'b0;
        tick(3);
        chk("rst_rdy", bus.in_ready, 0);
        chk("rst_req", bus.req_o, 0);
        chk("rst_data", bus.data_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_err", bus.err_o, 0);
        resetn = 1'b1;
        tick;
        chk("init1_rdy", bus.in_ready, 0);
        chk("init1_req", bus.req_o, 0);
        tick;
        chk("init2_rdy", bus.in_ready, 0);
        tick;
        chk("init3_rdy", bus.in_ready, 1);
        chk("init3_done", bus.done_o, 0);
        chk("init3_err", bus.err_o, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hA5A5_0001;
        tick;
        chk("s_req", bus.req_o, 1);
        chk("s_data", bus.data_o, 32'hA5A5_0001);
        chk("s_rdy_low", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        tick(4);
        chk("s_req_hold", bus.req_o, 1);
        bus.ack_i = 1'b1;
        tick(2);
        chk("s_req_prefall", bus.req_o, 1);
        tick;
        chk("s_req_fall", bus.req_o, 0);
        chk("s_err", bus.err_o, 0);
        bus.ack_i = 1'b0;
        tick(2);
        chk("s_done_early", bus.done_o, 0);
        chk("s_rdy_early", bus.in_ready, 0);
        tick;
        chk("s_done", bus.done_o, 1);
        chk("s_rdy", bus.in_ready, 1);
        tick;
        chk("s_done_pulse", bus.done_o, 0);
        chk("s_data_hold", bus.data_o, 32'hA5A5_0001);
        n_done = 0;
        bus.in_valid = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            bus.in_data = w;
            c = 0;
            while (!bus.in_ready && c < 20) begin tick; c++; end
            chk("b2b_rdy_wait", bus.in_ready, 1);
            tick;
            chk("b2b_req", bus.req_o, 1);
            chk("b2b_data", bus.data_o, w);
            bus.in_data  = w + 100;
            bus.in_valid = (w < 4);
            for (int k = 0; k < 4; k++) begin
                tick;
                chk("b2b_stable", bus.data_o, w);
            end
            bus.ack_i = 1'b1;
            c = 0;
            while (bus.req_o && c < 20) begin
                chk("b2b_stable_ack", bus.data_o, w);
                tick;
                c++;
            end
            chk("b2b_req_fall", bus.req_o, 0);
            bus.ack_i = 1'b0;
        end
        c = 0;
        while (!bus.in_ready && c < 20) begin tick; c++; end
        chk("b2b_final_rdy", bus.in_ready, 1);
        tick;
        chk("b2b_count", n_done, 4);
        chk("b2b_err", bus.err_o, 0);
        bus.ack_i = 1'b1;
        resetn = 1'b0;
        tick(2);
        chk("ar_rst_rdy", bus.in_ready, 0);
        resetn = 1'b1;
        tick(6);
        chk("ar_stuck_rdy", bus.in_ready, 0);
        chk("ar_stuck_req", bus.req_o, 0);
        bus.ack_i = 1'b0;
        tick(2);
        chk("ar_rdy_early", bus.in_ready, 0);
        tick;
        chk("ar_rdy", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        tick;
        chk("to_req", bus.req_o, 1);
        bus.in_valid = 1'b0;
        tick(7);
        chk("to_err_early", bus.err_o, 0);
        tick;
        chk("to_err", bus.err_o, 1);
        chk("to_req_hold", bus.req_o, 1);
        bus.err_clr = 1'b1;
        tick;
        chk("to_set_wins", bus.err_o, 1);
        bus.err_clr = 1'b0;
        bus.ack_i = 1'b1;
        tick(3);
        chk("to_req_fall", bus.req_o, 0);
        bus.ack_i = 1'b0;
        tick(3);
        chk("to_done", bus.done_o, 1);
        chk("to_err_sticky", bus.err_o, 1);
        bus.err_clr = 1'b1;
        tick;
        chk("to_err_clr", bus.err_o, 0);
        bus.err_clr = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1234_5678;
        tick;
        chk("mr_req_up", bus.req_o, 1);
        chk("mr_data_up", bus.data_o, 32'h1234_5678);
        bus.in_valid = 1'b0;
        tick(2);
        resetn = 1'b0;
        tick;
        chk("mr_req", bus.req_o, 0);
        chk("mr_data", bus.data_o, 0);
        chk("mr_rdy", bus.in_ready, 0);
        chk("mr_done", bus.done_o, 0);
        resetn = 1'b1;
        n_done = 0;
        tick(2);
        chk("mr_rdy_early", bus.in_ready, 0);
        tick;
        chk("mr_rdy_up", bus.in_ready, 1);
        tick;
        chk("mr_no_done", n_done, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
